// File: rtl/emif_pkg.sv
// Shared types and constants for the EMIF / local requester block RAM arbiter.
package emif_pkg;

    localparam int DW     = 16;
    localparam int AW_DEF = 12;
    localparam int SAT_W  = 16;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_WAIT = 2'd1,
        L_RD   = 2'd2
    } loc_state_e;

endpackage

// File: rtl/emif_dpram_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_cnt
    import emif_pkg::*;
#(
    parameter int W = SAT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/emif_dpram_arb.sv
// Single-port RAM arbiter: the EMIF bridge always wins, the local requester
// gets leftover cycles through a req/gnt handshake.
module emif_dpram_arb
    import emif_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             emif_wen,
    input  logic             emif_ren_2,
    input  logic [23:0]      emif_addr,
    input  logic [DW-1:0]    emif_wdata,
    output logic [DW-1:0]    emif_rdata,
    input  logic             loc_req,
    input  logic             loc_we,
    input  logic [AW-1:0]    loc_addr,
    input  logic [DW-1:0]    loc_wdata,
    output logic             loc_gnt,
    output logic             loc_rvalid,
    output logic [DW-1:0]    loc_rdata,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata,
    output logic             loc_starve,
    output logic             emif_conflict,
    input  logic             stat_clr,
    output logic [SAT_W-1:0] loc_stall_cnt
);

    localparam logic [SAT_W-1:0] STARVE_TH = SAT_W'(MAX_WAIT - 1);

    loc_state_e         state_q, state_d;
    logic               ren_2_q;
    logic               rd_d1_q, rd_d1_d;
    logic               starve_q, starve_d;
    logic               conflict_q, conflict_d;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic [DW-1:0]      hold_q, hold_d;
    logic               emif_rd_start;
    logic               emif_busy;
    logic               gnt_s;
    logic               wait_inc;
    logic [SAT_W-1:0]   wait_cnt;
    logic               emif_addr_unused;

    assign emif_addr_unused = ^emif_addr[23:AW];
    assign emif_rd_start    = emif_ren_2 & ~ren_2_q;
    assign emif_busy        = emif_wen | emif_rd_start;

    // RAM port mux: EMIF write, EMIF read start, then a waiting local access
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        gnt_s     = 1'b0;
        if (emif_wen) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = emif_addr[AW-1:0];
            ram_wdata = emif_wdata;
        end else if (emif_rd_start) begin
            ram_en   = 1'b1;
            ram_addr = emif_addr[AW-1:0];
        end else if ((state_q == L_WAIT) && loc_req) begin
            ram_en    = 1'b1;
            ram_we    = loc_we;
            ram_addr  = loc_addr;
            ram_wdata = loc_we ? loc_wdata : wdata_q;
            gnt_s     = 1'b1;
        end else begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    // local handshake FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            L_IDLE: begin
                if (loc_req) state_d = L_WAIT;
                else         state_d = L_IDLE;
            end
            L_WAIT: begin
                if (!loc_req)   state_d = L_IDLE;
                else if (gnt_s) state_d = loc_we ? L_IDLE : L_RD;
                else            state_d = L_WAIT;
            end
            L_RD:    state_d = L_IDLE;
            default: state_d = L_IDLE;
        endcase
    end

    // a blocked wait cycle is exactly a cycle the EMIF side took from us
    assign wait_inc = (state_q == L_WAIT) & loc_req & ~gnt_s;

    // sticky flags, read return path and hold register next values
    always_comb begin
        rd_d1_d = emif_rd_start & ~emif_wen;
        hold_d  = rd_d1_q ? ram_rdata : hold_q;
        if (stat_clr) begin
            starve_d   = 1'b0;
            conflict_d = 1'b0;
        end else begin
            starve_d   = starve_q | (wait_inc & (wait_cnt >= STARVE_TH));
            conflict_d = conflict_q | (emif_wen & emif_rd_start);
        end
    end

    // state, flag and data registers
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= L_IDLE;
            ren_2_q    <= 1'b0;
            rd_d1_q    <= 1'b0;
            starve_q   <= 1'b0;
            conflict_q <= 1'b0;
            addr_q     <= {AW{1'b0}};
            wdata_q    <= {DW{1'b0}};
            hold_q     <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            ren_2_q    <= emif_ren_2;
            rd_d1_q    <= rd_d1_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
            hold_q     <= hold_d;
        end
    end

    arb_sat_cnt #(.W(SAT_W)) u_wait_cnt (
        .clk   (clk_ref),
        .rst_n (rst_n),
        .clr   (~wait_inc),
        .inc   (wait_inc),
        .cnt   (wait_cnt)
    );

    arb_sat_cnt #(.W(SAT_W)) u_stall_cnt (
        .clk   (clk_ref),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (wait_inc),
        .cnt   (loc_stall_cnt)
    );

    assign emif_rdata    = hold_d;
    assign loc_gnt       = gnt_s;
    assign loc_rvalid    = (state_q == L_RD);
    assign loc_rdata     = (state_q == L_RD) ? ram_rdata : {DW{1'b0}};
    assign loc_starve    = starve_q;
    assign emif_conflict = conflict_q;

endmodule

// File: doc/emif_dpram_arb.md
Name: emif_dpram_arb

Overview:
- Shares one single-port 16-bit block RAM between two requesters: the EMIF bridge (DSP side) and one local FPGA-side requester (DMA/control logic).
- The EMIF side has absolute priority because the DSP asynchronous bus cannot be stalled.
- The local side uses a req/gnt handshake and gets any cycle the EMIF side leaves free.
- Sits between the EMIF bridge outputs (wen pulse, ren_2 window, addr, wdata, rdata return) and the RAM primitive.

Parameters:
- AW, 12, RAM address width; EMIF address bits [AW-1:0] are used, upper bits are ignored.
- DW, 16, data width; fixed to the EMIF bus width.
- MAX_WAIT, 64, local wait cycles before the starvation flag is set.

Ports:
- clk_ref  in  1  system clock, same domain as the EMIF bridge
- rst_n  in  1  reset; asynchronous, active-low
- emif_wen  in  1  EMIF write strobe, 1-cycle pulse
- emif_ren_2  in  1  EMIF read window, 2 cycles high per read
- emif_addr  in  24  EMIF word address
- emif_wdata  in  DW  EMIF write data
- emif_rdata  out  DW  read data returned to the bridge
- loc_req  in  1  local request; must be held until loc_gnt
- loc_we  in  1  local write (1) or read (0), stable while loc_req is high
- loc_addr  in  AW  local address
- loc_wdata  in  DW  local write data
- loc_gnt  out  1  1-cycle grant; the access executes in this cycle
- loc_rvalid  out  1  1-cycle pulse, loc_rdata valid
- loc_rdata  out  DW  local read data
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, 1-cycle latency after ram_en
- loc_starve  out  1  sticky flag: local waited at least MAX_WAIT cycles
- emif_conflict  out  1  sticky flag: emif_wen and a read start occurred in the same cycle
- stat_clr  in  1  synchronous clear of the sticky flags and loc_stall_cnt
- loc_stall_cnt  out  16  saturating count of cycles where loc_req was blocked by EMIF

Behaviour:
- Reset values:
  - All flops clear to 0; emif_rdata hold register clears to 0.
  - Local FSM goes to L_IDLE.
  - Any pending local read is dropped; no loc_rvalid is issued after reset.
- EMIF read start: emif_rd_start = emif_ren_2 & ~ren_2_q (rising edge of the read window).
- RAM port mux, combinational, evaluated in this priority order:
  1. emif_wen: ram_en=1, ram_we=1, ram_addr=emif_addr[AW-1:0], ram_wdata=emif_wdata.
  2. else emif_rd_start: ram_en=1, ram_we=0, ram_addr=emif_addr[AW-1:0].
  3. else if FSM is in L_WAIT and loc_req=1: local access with ram_we=loc_we, and loc_gnt=1.
  4. else ram_en=0 and ram_we=0; addr/wdata hold their last value.
- EMIF read return:
  - emif_rd_d1 = registered emif_rd_start.
  - In the cycle where emif_rd_d1=1: emif_rdata = ram_rdata (combinational path), and the same value loads the hold register.
  - In all other cycles: emif_rdata = hold register. This keeps the value stable for the whole ren_2 window and beyond.
- Local FSM:
  - L_IDLE:
    - loc_req=1 → L_WAIT.
    - Grant is not given in L_IDLE, so minimum request-to-grant latency is 1 cycle.
  - L_WAIT:
    - If loc_req is deasserted before grant: abort, → L_IDLE, no RAM access.
    - If granted with loc_we=1: → L_IDLE.
    - If granted with loc_we=0: → L_RD.
  - L_RD:
    - loc_rvalid=1 and loc_rdata=ram_rdata for exactly one cycle; → L_IDLE.
    - An EMIF access in this cycle is allowed; the RAM output still reflects the local address.
- Back-to-back local accesses:
  - Next grant comes no earlier than 2 cycles after the previous grant for writes, 3 cycles for reads.
  - The requester may hold loc_req high continuously.
- Wait counter:
  - Increments each cycle in L_WAIT without a grant; clears on grant or on L_IDLE.
  - Reaching MAX_WAIT sets loc_starve (sticky).
  - loc_stall_cnt increments, saturating at 16'hFFFF, on each L_WAIT cycle blocked by emif_wen or emif_rd_start.
- Simultaneous emif_wen and emif_rd_start:
  - The write executes.
  - The read is served from the stale hold register.
  - emif_conflict is set (sticky).
- stat_clr takes priority over the same-cycle set of any sticky flag or counter.
- No address-range checks; addresses wrap modulo 2^AW.

Decomposition:
- Shared package emif_pkg holds:
  - Local FSM state enum {L_IDLE, L_WAIT, L_RD}.
  - DW=16 constant.
  - Default AW.
  - Saturating-counter width constant.
- One natural sub-module, arb_sat_cnt: a parameterised saturating counter with inc, clr and width, used for loc_stall_cnt and the wait counter.
- The arbiter mux and FSM stay in the top module.

Test Plan:
- Local write only:
  - Stimulus: loc_req=1, loc_we=1, addr=0x010, data=0xA5A5.
  - Required: loc_gnt one cycle after req; ram_we=1 in the same cycle with addr 0x010.
  - Then a local read of 0x010: loc_rvalid one cycle after gnt with loc_rdata=0xA5A5.
- EMIF write then read:
  - Stimulus: emif_wen pulse, addr=0x000123, data=0x1234; then a 2-cycle ren_2 window at addr 0x000123.
  - Required: ram_en at ren_2 rise; emif_rdata=0x1234 from the second cycle; value held after ren_2 falls.
- Contention:
  - Stimulus: loc_req held in L_WAIT while emif_wen pulses on 3 consecutive cycles.
  - Required: no loc_gnt during those cycles; grant on the 4th cycle; loc_stall_cnt=3.
- Starvation and clear:
  - Stimulus: MAX_WAIT=4; EMIF busy for 6 cycles while loc_req=1.
  - Required: loc_starve=1 after 4 waiting cycles; stat_clr drives loc_starve=0 and loc_stall_cnt=0.
- Conflict:
  - Stimulus: emif_wen and ren_2 rise in the same cycle.
  - Required: write executes; emif_conflict=1; emif_rdata unchanged.
- Reset mid-read:
  - Stimulus: assert rst_n=0 in the cycle after a local read grant.
  - Required: no loc_rvalid; all outputs 0; FSM in L_IDLE on release.
